// File: rtl/framer_pkg.sv
// Shared types and defaults for the sample framer.
// Optional build macro FRAMER_DROP_CNT_EN adds the dropped-sample counter.
package framer_pkg;

    localparam int DEF_DATA_W    = 12;
    localparam int DEF_FRAME_LEN = 36;
    localparam int DEF_CNT_W     = 6;
    localparam int DROP_CNT_W    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } framer_state_e;

endpackage

// File: rtl/framer_bank_ram.sv
// Two-bank frame store: one synchronous write port, one asynchronous read port.
module framer_bank_ram #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 36,
    parameter int CNT_W     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2][FRAME_LEN];

    // Contents need no reset: a bank is only read once its full flag is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/sample_framer.sv
// Ping-pong framer: collects a non-stallable sample stream into frames and
// streams each full frame out with ack handshake. Macro: FRAMER_DROP_CNT_EN.
module sample_framer
    import framer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] x_out,
    output logic              x_valid,
    input  logic              x_ack,
    output logic              x_last,
    output logic              frame_sent,
    output logic              overflow
`ifdef FRAMER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic             ONE_LEN  = (FRAME_LEN == 1);

    framer_state_e     state_q, state_d;
    logic [CNT_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [DATA_W-1:0] x_out_q, x_out_d;
    logic              x_valid_q, x_valid_d, x_last_q, x_last_d;
    logic              frame_sent_q, frame_sent_d, overflow_q, overflow_d;
`ifdef FRAMER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

    logic              we;
    logic              ram_rd_bank;
    logic [CNT_W-1:0]  ram_rd_idx;
    logic [DATA_W-1:0] ram_rd_data;

    framer_bank_ram #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_bank (wr_bank_q),
        .wr_idx  (wr_idx_q),
        .wr_data (s_data),
        .rd_bank (ram_rd_bank),
        .rd_idx  (ram_rd_idx),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        wr_bank_d    = wr_bank_q;
        rd_idx_d     = rd_idx_q;
        rd_bank_d    = rd_bank_q;
        bank_full_d  = bank_full_q;
        x_out_d      = x_out_q;
        x_valid_d    = x_valid_q;
        x_last_d     = x_last_q;
        frame_sent_d = 1'b0;
        overflow_d   = overflow_q;
`ifdef FRAMER_DROP_CNT_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        we           = 1'b0;
        ram_rd_bank  = rd_bank_q;
        ram_rd_idx   = '0;

        // Full flag is judged on the registered value, so a bank being
        // released this cycle still rejects the incoming sample.
        if (s_valid) begin
            if (bank_full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
`ifdef FRAMER_DROP_CNT_EN
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
`endif
            end else begin
                we = 1'b1;
                if (wr_idx_q == LAST_IDX) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_idx_d               = '0;
                    wr_bank_d              = ~wr_bank_q;
                end else begin
                    wr_idx_d = wr_idx_q + CNT_W'(1);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d   = SEND;
                    rd_idx_d  = '0;
                    x_out_d   = ram_rd_data;
                    x_valid_d = 1'b1;
                    x_last_d  = ONE_LEN;
                end
            end
            SEND: begin
                if (x_ack) begin
                    if (!x_last_q) begin
                        rd_idx_d   = rd_idx_q + CNT_W'(1);
                        ram_rd_idx = rd_idx_q + CNT_W'(1);
                        x_out_d    = ram_rd_data;
                        x_last_d   = (rd_idx_q + CNT_W'(1) == LAST_IDX);
                    end else begin
                        bank_full_d[rd_bank_q] = 1'b0;
                        rd_bank_d              = ~rd_bank_q;
                        frame_sent_d           = 1'b1;
                        // Chain straight into the other bank when it is ready.
                        if (bank_full_q[~rd_bank_q]) begin
                            rd_idx_d    = '0;
                            ram_rd_bank = ~rd_bank_q;
                            x_out_d     = ram_rd_data;
                            x_last_d    = ONE_LEN;
                        end else begin
                            state_d   = IDLE;
                            x_valid_d = 1'b0;
                            x_last_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_idx_q     <= '0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= '0;
            x_out_q      <= '0;
            x_valid_q    <= 1'b0;
            x_last_q     <= 1'b0;
            frame_sent_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef FRAMER_DROP_CNT_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            wr_bank_q    <= wr_bank_d;
            rd_idx_q     <= rd_idx_d;
            rd_bank_q    <= rd_bank_d;
            bank_full_q  <= bank_full_d;
            x_out_q      <= x_out_d;
            x_valid_q    <= x_valid_d;
            x_last_q     <= x_last_d;
            frame_sent_q <= frame_sent_d;
            overflow_q   <= overflow_d;
`ifdef FRAMER_DROP_CNT_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign x_last     = x_last_q;
    assign frame_sent = frame_sent_q;
    assign overflow   = overflow_q;
`ifdef FRAMER_DROP_CNT_EN
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sample_framer.sv
// Randomized + directed bench for sample_framer against a frame-queue reference model.
module tb_sample_framer;
    localparam int L = 36;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [11:0] s_data;
    logic [11:0] x_out;
    logic        x_valid;
    logic        x_ack;
    logic        x_last;
    logic        frame_sent;
    logic        overflow;
`ifdef FRAMER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    sample_framer dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .x_ack      (x_ack),
        .x_last     (x_last),
        .frame_sent (frame_sent),
        .overflow   (overflow)
`ifdef FRAMER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: completed frames wait in held_q (oldest first), the
    // partially collected frame in fill_q. The writer's bank is full exactly
    // when two completed frames are still held.
    int held_q[$];
    int fill_q[$];
    bit m_valid;
    int m_pos;
    int last_out;
    bit m_fs;
    bit m_ovf;
    int m_drops;

    task automatic model_update(input bit sv, input int sd, input bit ack, input bit rst);
        int pre_held;
        if (rst) begin
            held_q.delete(); fill_q.delete();
            m_valid = 0; m_pos = 0; last_out = 0; m_fs = 0; m_ovf = 0; m_drops = 0;
            return;
        end
        pre_held = held_q.size() / L;
        m_fs = 0;
        if (m_valid) begin
            if (ack) begin
                if (m_pos < L - 1) m_pos++;
                else begin
                    repeat (L) void'(held_q.pop_front());
                    m_fs = 1;
                    if (pre_held == 2) m_pos = 0;
                    else m_valid = 0;
                end
            end
        end else if (pre_held >= 1) begin
            m_valid = 1;
            m_pos = 0;
        end
        if (sv) begin
            if (pre_held == 2) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end else begin
                fill_q.push_back(sd);
                if (fill_q.size() == L) begin
                    foreach (fill_q[i]) held_q.push_back(fill_q[i]);
                    fill_q.delete();
                end
            end
        end
        if (m_valid) last_out = held_q[m_pos];
    endtask

    // One clock: drive, let the edge happen, update model, compare on negedge.
    task automatic step(input bit sv, input int sd, input bit ack, input bit rst);
        reset = rst; s_valid = sv; s_data = 12'(sd); x_ack = ack;
        @(posedge clk);
        model_update(sv, sd, ack, rst);
        @(negedge clk);
        chk("x_valid", 32'(x_valid), 32'(m_valid));
        chk("x_out", 32'(x_out), 32'(last_out));
        chk("x_last", 32'(x_last), 32'(m_valid && m_pos == L - 1));
        chk("frame_sent", 32'(frame_sent), 32'(m_fs));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FRAMER_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    initial begin
        int hold;
        bit ack;
        int sent;
        reset = 1; s_valid = 0; s_data = 0; x_ack = 0;
        @(negedge clk);
        step(0, 0, 0, 1);
        step(1, 7, 1, 1);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Straight frame, ack tied high.
        sent = 0;
        for (int i = 0; i < L; i++) step(1, 100 + i, 1, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 1, 0);
            if (frame_sent) sent++;
        end
        chk("basic_frames_sent", 32'(sent), 32'd1);
        chk("basic_overflow", 32'(overflow), 32'd0);

        // Backpressure: hold 3 cycles on sample 105.
        hold = 0;
        for (int i = 0; i < L + 45; i++) begin
            ack = !(m_valid && last_out == 105 && hold < 3);
            if (!ack) hold++;
            step(i < L, 100 + i, ack, 0);
        end
        chk("bp_hold_cycles", 32'(hold), 32'd3);

        // Overflow: both banks fill, 8 samples dropped, then drain.
        for (int i = 0; i < 80; i++) step(1, i, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_x_out", 32'(x_out), 32'd0);
        chk("ovf_x_valid", 32'(x_valid), 32'd1);
`ifdef FRAMER_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd8);
`endif
        for (int i = 0; i < 80; i++) step(0, 0, 1, 0);
        chk("ovf_drained", 32'(x_valid), 32'd0);

        // Continuous stream from 200 with ack high.
        step(0, 0, 0, 1);
        for (int i = 0; i < 160; i++) step(1, 200 + i, 1, 0);
        for (int i = 0; i < 80; i++) step(0, 0, 1, 0);

        // Reset mid-frame while 117 is presented.
        step(0, 0, 0, 1);
        for (int i = 0; i < L; i++) step(1, 100 + i, 1, 0);
        for (int i = 0; i < 40 && !(x_valid && x_out == 12'd117); i++) step(0, 0, 1, 0);
        chk("mid_at_117", 32'(x_out), 32'd117);
        step(0, 0, 1, 1);
        chk("mid_rst_x_out", 32'(x_out), 32'd0);
        chk("mid_rst_x_valid", 32'(x_valid), 32'd0);
        for (int i = 0; i < L; i++) step(1, 300 + i, 0, 0);
        for (int i = 0; i < 10 && !x_valid; i++) step(0, 0, 0, 0);
        chk("mid_first_valid", 32'(x_valid), 32'd1);
        chk("mid_first_sample", 32'(x_out), 32'd300);
        for (int i = 0; i < 45; i++) step(0, 0, 1, 0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 599) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
